// File: rtl/projm_sram_responder_if.sv
// Request/response and word-serial load bus between the spatial encoder (master)
// and one modality's projection-matrix responder (slave).
interface projm_sram_responder_if #(
    parameter int HV_DIM = 64,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic                ReqValid_SI;
    logic                ReqReady_SO;
    logic [ADDR_W-1:0]   ReqAddr_DI;
    logic                RspValid_SO;
    logic                RspReady_SI;
    logic [0:HV_DIM-1]   ProjPos_DO;
    logic [0:HV_DIM-1]   ProjNeg_DO;
    logic                LoadValid_SI;
    logic                LoadReady_SO;
    logic                LoadSel_SI;
    logic [ADDR_W-1:0]   LoadAddr_DI;
    logic [WORD_W-1:0]   LoadWord_DI;
    logic                AddrErr_SO;

    modport slave (
        input  ReqValid_SI, ReqAddr_DI, RspReady_SI,
        input  LoadValid_SI, LoadSel_SI, LoadAddr_DI, LoadWord_DI,
        output ReqReady_SO, RspValid_SO, ProjPos_DO, ProjNeg_DO,
        output LoadReady_SO, AddrErr_SO
    );

    modport master (
        output ReqValid_SI, ReqAddr_DI, RspReady_SI,
        output LoadValid_SI, LoadSel_SI, LoadAddr_DI, LoadWord_DI,
        input  ReqReady_SO, RspValid_SO, ProjPos_DO, ProjNeg_DO,
        input  LoadReady_SO, AddrErr_SO
    );
endinterface

// File: rtl/projm_sram_responder.sv
// Projection-matrix responder: pos/neg row banks, 1-cycle registered responses,
// word-serial row loader. Define HDC_PROJM_PARITY_EN for per-row parity checking.
module projm_sram_responder #(
    parameter int HV_DIM = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic                  Clk_CI,
    input  logic                  Reset_RI,
    projm_sram_responder_if.slave bus
`ifdef HDC_PROJM_PARITY_EN
    ,
    output logic                  ParityErr_SO
`endif
);
    localparam int          WPR     = HV_DIM / WORD_W;
    localparam int          CNT_W   = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic {ST_IDLE, ST_LOAD} state_t;
    state_t r_state, w_state_next;

    logic [0:HV_DIM-1] r_mem_pos [DEPTH];
    logic [0:HV_DIM-1] r_mem_neg [DEPTH];
    logic [DEPTH-1:0]  r_wr_pos, r_wr_neg;
    logic [CNT_W-1:0]  r_cnt;
    logic [0:HV_DIM-1] r_asm;
    logic              r_sel;
    logic [ADDR_W-1:0] r_load_addr;
    logic              r_rsp_valid, r_addr_err;
    logic [0:HV_DIM-1] r_pos, r_neg;

    logic              w_req_fire, w_rsp_done, w_load_fire, w_load_last, w_commit;
    logic              w_req_ok, w_commit_ok, w_commit_sel;
    logic [CNT_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_raddr, w_commit_addr, w_waddr;
    logic [0:HV_DIM-1] w_row, w_rd_pos, w_rd_neg;

    assign w_req_fire  = bus.ReqValid_SI & bus.ReqReady_SO;
    assign w_rsp_done  = r_rsp_valid & bus.RspReady_SI;
    assign w_load_fire = bus.LoadValid_SI & bus.LoadReady_SO;

    // Out-of-range addresses are steered to row 0 so the array is never indexed past its end
    assign w_req_ok = 32'(bus.ReqAddr_DI) < DEPTH_U;
    assign w_raddr  = w_req_ok ? bus.ReqAddr_DI : '0;
    assign w_rd_pos = r_mem_pos[w_raddr];
    assign w_rd_neg = r_mem_neg[w_raddr];

    // The first word of a row is taken straight from the load inputs while still IDLE
    assign w_idx         = (r_state == ST_LOAD) ? r_cnt : '0;
    assign w_load_last   = (32'(w_idx) == 32'(WPR - 1));
    assign w_commit      = w_load_fire & w_load_last;
    assign w_commit_sel  = (r_state == ST_LOAD) ? r_sel : bus.LoadSel_SI;
    assign w_commit_addr = (r_state == ST_LOAD) ? r_load_addr : bus.LoadAddr_DI;
    assign w_commit_ok   = 32'(w_commit_addr) < DEPTH_U;
    assign w_waddr       = w_commit_ok ? w_commit_addr : '0;

    always_comb begin
        w_row = (r_state == ST_LOAD) ? r_asm : '0;
        w_row[int'(w_idx) * WORD_W +: WORD_W] = bus.LoadWord_DI;
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        bus.ReqReady_SO  = 1'b0;
        bus.LoadReady_SO = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.ReqReady_SO  = ~r_rsp_valid | bus.RspReady_SI;
                bus.LoadReady_SO = ~bus.ReqValid_SI;
                if (bus.LoadValid_SI && !bus.ReqValid_SI && !w_load_last)
                    w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                bus.LoadReady_SO = 1'b1;
                if (bus.LoadValid_SI && w_load_last)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Row storage carries no reset so it can map onto block RAM
    always_ff @(posedge Clk_CI) begin
        if (w_commit && w_commit_ok) begin
            if (w_commit_sel) r_mem_neg[w_waddr] <= w_row;
            else              r_mem_pos[w_waddr] <= w_row;
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            r_cnt       <= '0;
            r_asm       <= '0;
            r_sel       <= 1'b0;
            r_load_addr <= '0;
            r_wr_pos    <= '0;
            r_wr_neg    <= '0;
            r_rsp_valid <= 1'b0;
            r_pos       <= '0;
            r_neg       <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            if (w_load_fire) begin
                r_asm <= w_row;
                if (r_state == ST_IDLE) begin
                    r_sel       <= bus.LoadSel_SI;
                    r_load_addr <= bus.LoadAddr_DI;
                end
                r_cnt <= w_load_last ? '0 : w_idx + CNT_W'(1);
                if (w_load_last) begin
                    if (!w_commit_ok)      r_addr_err         <= 1'b1;
                    else if (w_commit_sel) r_wr_neg[w_waddr] <= 1'b1;
                    else                   r_wr_pos[w_waddr] <= 1'b1;
                end
            end
            if (w_req_fire) begin
                r_rsp_valid <= 1'b1;
                r_pos       <= (w_req_ok && r_wr_pos[w_raddr]) ? w_rd_pos : '0;
                r_neg       <= (w_req_ok && r_wr_neg[w_raddr]) ? w_rd_neg : '0;
                if (!w_req_ok) r_addr_err <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef HDC_PROJM_PARITY_EN
    logic r_par_pos [DEPTH];
    logic r_par_neg [DEPTH];
    logic r_perr;
    logic w_par_bad;

    always_ff @(posedge Clk_CI) begin
        if (w_commit && w_commit_ok) begin
            if (w_commit_sel) r_par_neg[w_waddr] <= ^w_row;
            else              r_par_pos[w_waddr] <= ^w_row;
        end
    end

    assign w_par_bad = w_req_ok &&
        ((r_wr_pos[w_raddr] && ((^w_rd_pos) != r_par_pos[w_raddr])) ||
         (r_wr_neg[w_raddr] && ((^w_rd_neg) != r_par_neg[w_raddr])));

    // Pulses only in the first cycle of a fresh response
    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) r_perr <= 1'b0;
        else           r_perr <= w_req_fire & w_par_bad;
    end

    assign ParityErr_SO = r_perr;
`endif

    assign bus.RspValid_SO = r_rsp_valid;
    assign bus.ProjPos_DO  = r_pos;
    assign bus.ProjNeg_DO  = r_neg;
    assign bus.AddrErr_SO  = r_addr_err;
endmodule

// File: tb/tb_projm_sram_responder.sv
// Directed bench for projm_sram_responder: expected responses are queued at request
// acceptance and a negedge monitor checks every presented response against the queue.
module tb_projm_sram_responder;
    localparam int HV = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    projm_sram_responder_if #(.HV_DIM(HV), .ADDR_W(8), .WORD_W(32)) bus ();
`ifdef HDC_PROJM_PARITY_EN
    logic perr;
`endif

    projm_sram_responder #(.HV_DIM(HV), .DEPTH(200), .ADDR_W(8), .WORD_W(32)) dut (
        .Clk_CI   (clk),
        .Reset_RI (rst_n),
        .bus      (bus)
`ifdef HDC_PROJM_PARITY_EN
        ,
        .ParityErr_SO (perr)
`endif
    );

    typedef struct {
        int          addr;
        logic [63:0] pos;
        logic [63:0] neg;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every cycle a response is presented; pop when it completes
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.RspValid_SO === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: got pos=%h neg=%h, expected no response",
                             bus.ProjPos_DO, bus.ProjNeg_DO);
                end else if (bus.ProjPos_DO !== sb[0].pos || bus.ProjNeg_DO !== sb[0].neg) begin
                    n_err++;
                    $display("FAIL rsp_addr%0d: got pos=%h neg=%h, expected pos=%h neg=%h",
                             sb[0].addr, bus.ProjPos_DO, bus.ProjNeg_DO, sb[0].pos, sb[0].neg);
                    if (bus.RspReady_SI) void'(sb.pop_front());
                end else if (bus.RspReady_SI) begin
                    $display("rsp addr=%0d pos=%h neg=%h", sb[0].addr, bus.ProjPos_DO, bus.ProjNeg_DO);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic req(input logic [7:0] a, input logic [63:0] ep, input logic [63:0] en);
        int n = 0;
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = a;
        @(negedge clk);
        while (!bus.ReqReady_SO && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ReqReady_SO) chk("req_timeout", {63'd0, bus.ReqReady_SO}, 64'd1);
        else sb.push_back('{int'(a), ep, en});
        @(posedge clk); #1;
        bus.ReqValid_SI = 1'b0;
        chk("rsp_latency", {63'd0, bus.RspValid_SO}, 64'd1);
    endtask

    // Later words drive a different sel/addr to confirm they are latched on the first word
    task automatic load_row(input logic sel, input logic [7:0] a,
                            input logic [31:0] w0, input logic [31:0] w1, input int gap);
        logic [31:0] w [2];
        w[0] = w0;
        w[1] = w1;
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            bus.LoadValid_SI = 1'b1;
            bus.LoadSel_SI   = (k == 0) ? sel : ~sel;
            bus.LoadAddr_DI  = (k == 0) ? a : (a ^ 8'h01);
            bus.LoadWord_DI  = w[k];
            @(negedge clk);
            while (!bus.LoadReady_SO && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!bus.LoadReady_SO) chk("load_timeout", {63'd0, bus.LoadReady_SO}, 64'd1);
            @(posedge clk); #1;
            bus.LoadValid_SI = 1'b0;
            if (k == 0) repeat (gap) begin @(posedge clk); #1; end
        end
        $display("load sel=%0d row=%0d words=%h %h", sel, a, w0, w1);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.ReqValid_SI  = 1'b0;
        bus.ReqAddr_DI   = '0;
        bus.RspReady_SI  = 1'b1;
        bus.LoadValid_SI = 1'b0;
        bus.LoadSel_SI   = 1'b0;
        bus.LoadAddr_DI  = '0;
        bus.LoadWord_DI  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {63'd0, bus.RspValid_SO}, 64'd0);
        chk("reset_pos", bus.ProjPos_DO, 64'd0);
        chk("reset_neg", bus.ProjNeg_DO, 64'd0);
        chk("reset_addr_err", {63'd0, bus.AddrErr_SO}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {63'd0, bus.ReqReady_SO}, 64'd1);
        chk("idle_load_ready", {63'd0, bus.LoadReady_SO}, 64'd1);
        @(posedge clk); #1;

        // Unwritten row reads as zero
        req(8'd5, 64'd0, 64'd0);
        @(negedge clk);
        chk("addr_err_clean", {63'd0, bus.AddrErr_SO}, 64'd0);
        @(posedge clk); #1;

        load_row(1'b0, 8'd3, 32'hDEADBEEF, 32'h01234567, 0);
        load_row(1'b1, 8'd4, 32'h0F0F0F0F, 32'hA5A5A5A5, 2);
        req(8'd3, 64'hDEADBEEF01234567, 64'd0);
        @(posedge clk); #1;

        // Back-to-back 3,4,3 with a two-cycle consumer stall on the first response
        bus.RspReady_SI = 1'b0;
        fork
            begin
                req(8'd3, 64'hDEADBEEF01234567, 64'd0);
                req(8'd4, 64'd0, 64'h0F0F0F0FA5A5A5A5);
                req(8'd3, 64'hDEADBEEF01234567, 64'd0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!bus.RspValid_SO && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_req_ready_1", {63'd0, bus.ReqReady_SO}, 64'd0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("stall_req_ready_2", {63'd0, bus.ReqReady_SO}, 64'd0);
                @(posedge clk); #1;
                bus.RspReady_SI = 1'b1;
            end
        join
        @(posedge clk); #1;

        // Request and load together: request wins, load follows; requests blocked in LOAD
        bus.ReqValid_SI  = 1'b1;
        bus.ReqAddr_DI   = 8'd3;
        bus.LoadValid_SI = 1'b1;
        bus.LoadSel_SI   = 1'b1;
        bus.LoadAddr_DI  = 8'd9;
        bus.LoadWord_DI  = 32'h11111111;
        @(negedge clk);
        chk("prio_req_ready", {63'd0, bus.ReqReady_SO}, 64'd1);
        chk("prio_load_blocked", {63'd0, bus.LoadReady_SO}, 64'd0);
        sb.push_back('{3, 64'hDEADBEEF01234567, 64'd0});
        @(posedge clk); #1;
        bus.ReqValid_SI = 1'b0;
        @(negedge clk);
        chk("load_after_req", {63'd0, bus.LoadReady_SO}, 64'd1);
        @(posedge clk); #1;
        bus.LoadWord_DI = 32'h22222222;
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'd9;
        @(negedge clk);
        chk("req_blocked_in_load", {63'd0, bus.ReqReady_SO}, 64'd0);
        chk("load_ready_in_load", {63'd0, bus.LoadReady_SO}, 64'd1);
        @(posedge clk); #1;
        bus.LoadValid_SI = 1'b0;
        req(8'd9, 64'd0, 64'h1111111122222222);
        @(posedge clk); #1;

        // Out-of-range request, sticky error
        req(8'd255, 64'd0, 64'd0);
        @(negedge clk);
        chk("addr_err_set", {63'd0, bus.AddrErr_SO}, 64'd1);
        @(posedge clk); #1;
        req(8'd3, 64'hDEADBEEF01234567, 64'd0);
        @(negedge clk);
        chk("addr_err_sticky", {63'd0, bus.AddrErr_SO}, 64'd1);
        @(posedge clk); #1;

`ifdef HDC_PROJM_PARITY_EN
        load_row(1'b0, 8'd1, 32'h00000001, 32'h00000003, 0);
        dut.r_mem_pos[1][63] = ~dut.r_mem_pos[1][63];
        req(8'd1, 64'h0000000100000002, 64'd0);
        chk("parity_pulse", {63'd0, perr}, 64'd1);
        @(posedge clk); #1;
        chk("parity_clear", {63'd0, perr}, 64'd0);
`endif

        // Pending response held across a load start, then async reset mid-load
        bus.RspReady_SI = 1'b0;
        req(8'd5, 64'd0, 64'd0);
        bus.LoadValid_SI = 1'b1;
        bus.LoadSel_SI   = 1'b0;
        bus.LoadAddr_DI  = 8'd7;
        bus.LoadWord_DI  = 32'hCAFEF00D;
        @(negedge clk);
        chk("load_with_pending_rsp", {63'd0, bus.LoadReady_SO}, 64'd1);
        @(posedge clk); #1;
        bus.LoadValid_SI = 1'b0;
        @(negedge clk);
        chk("req_ready_in_load", {63'd0, bus.ReqReady_SO}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rsp_valid", {63'd0, bus.RspValid_SO}, 64'd0);
        sb.delete();
        bus.RspReady_SI = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("addr_err_after_reset", {63'd0, bus.AddrErr_SO}, 64'd0);
        @(posedge clk); #1;
        req(8'd7, 64'd0, 64'd0);
        req(8'd3, 64'd0, 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/projm_sram_responder.md
Name: projm_sram_responder

Overview:
- Memory-side responder for the spatial encoder's projection-matrix fetch protocol; one instance serves one modality.
- Holds the positive and negative projection rows for that modality.
- Serves address requests (encoder valid + sram_addr) with a registered response (sram valid + pos/neg row) under valid/ready flow control.
- Has a narrow word-serial load port so firmware or a bench can program rows before inference.

Parameters:
HV_DIM, 64, hypervector width in bits; must be a multiple of WORD_W
DEPTH, 256, number of rows per polarity
ADDR_W, 8, request/load address width
WORD_W, 32, load word width

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  asynchronous active-low reset
ReqValid_SI  in  1  encoder request valid (encoder spatial_valid)
ReqReady_SO  out  1  responder accepts request (sram_ready)
ReqAddr_DI  in  ADDR_W  row address (sram_addr)
RspValid_SO  out  1  response valid (sram_valid)
RspReady_SI  in  1  encoder accepts response (encoder spatial_ready)
ProjPos_DO  out  [0:HV_DIM-1]  positive projection row
ProjNeg_DO  out  [0:HV_DIM-1]  negative projection row
LoadValid_SI  in  1  load word valid
LoadReady_SO  out  1  load word accepted
LoadSel_SI  in  1  0 = pos bank, 1 = neg bank; sampled on first word
LoadAddr_DI  in  ADDR_W  target row; sampled on first word
LoadWord_DI  in  WORD_W  data word
AddrErr_SO  out  1  sticky out-of-range address flag

Behaviour:
- Reset (async, Reset_RI=0):
  - Outputs: RspValid_SO=0, ProjPos_DO=0, ProjNeg_DO=0, AddrErr_SO=0.
  - Internal: all per-row written bits cleared, word counter=0, FSM=IDLE.
  - Row storage is not reset.
  - Reset mid-load discards the partial row.
- Derived constant: WPR = HV_DIM/WORD_W words per row.
- FSM states:
  - IDLE: requests and loads allowed.
  - LOAD: row assembly in progress; requests blocked.
- ReqReady_SO = (state==IDLE) & (~RspValid_SO | RspReady_SI). Single-entry response register; full throughput when the consumer is always ready.
- Request handshake (ReqValid_SI & ReqReady_SO):
  - Next cycle: RspValid_SO=1, and ProjPos_DO/ProjNeg_DO carry the row at ReqAddr_DI. Latency is 1 cycle.
  - Row never written: returns all zeros for that polarity.
  - ReqAddr_DI >= DEPTH: returns zeros for both polarities and sets AddrErr_SO (sticky until reset).
- Response handshake:
  - RspValid_SO stays 1 and data is held stable until RspReady_SI=1.
  - A completed response with no new request clears RspValid_SO next cycle.
  - Completion and a new accepted request in the same cycle: RspValid_SO stays 1 with the new data.
- LoadReady_SO = (state==LOAD) | (state==IDLE & ~ReqValid_SI). A request has priority over starting a load in the same cycle.
- Load sequence:
  - First accepted word in IDLE: latch LoadSel/LoadAddr, place the word at bits [0:WORD_W-1], counter=1, go to LOAD. If WPR==1, commit immediately and stay in IDLE.
  - Word k fills bits [k*WORD_W : (k+1)*WORD_W-1].
  - On word WPR-1: commit the assembled row to the selected bank/row, set that row's written bit, counter=0, return to IDLE.
  - Load address >= DEPTH: words are still consumed, the commit is dropped, and AddrErr_SO is set.
  - Load gaps (LoadValid_SI=0) in LOAD: state and counter held.
- Pending response during a load: continues to be held and can complete; only new requests are blocked.
- Read-after-commit: a request accepted the cycle after commit returns the new data.

Optional Feature:
- Macro: HDC_PROJM_PARITY_EN.
- When defined:
  - Each bank/row stores an even-parity bit computed at commit.
  - Extra output ParityErr_SO (1 bit, reset 0) pulses for one cycle together with the first cycle of RspValid_SO whenever the recomputed parity of a returned written row mismatches.
  - Unwritten rows never flag.
- When undefined: no parity storage, no ParityErr_SO port.

Test Plan:
- Reset, then request addr 5 with RspReady_SI=1 -> RspValid_SO=1 one cycle later, ProjPos_DO=ProjNeg_DO=0, AddrErr_SO=0.
- Load pos row 3 with words 0xDEADBEEF then 0x01234567 (HV_DIM=64), then request 3 -> ProjPos_DO=0xDEADBEEF01234567, ProjNeg_DO=0.
- Back-to-back requests 3,4,3 with RspReady_SI held 0 for 2 cycles after the first response -> ReqReady_SO=0 during stall, first response data stable, all three responses in order, no drops.
- ReqValid_SI and LoadValid_SI asserted together in IDLE -> request accepted, LoadReady_SO=0 that cycle, load accepted next cycle; request issued while in LOAD sees ReqReady_SO=0 until commit.
- Request addr 255 with DEPTH=200 -> zero data, AddrErr_SO=1 and stays 1 across later good requests until reset.
- Assert Reset_RI=0 after first load word of row 7, release, request 7 -> zero data; with HDC_PROJM_PARITY_EN, load row 1, force one stored bit flip, request 1 -> ParityErr_SO=1 for one cycle.
